aes_round_engine: RTL and testbench
===================================

AES_ROUND_ENGINE -- requirements
Module: aes_round_engine

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, meaning AES-128 round count; only the value 10 is supported.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the completed-block counter.
REQ-003 clk  input  1  single clock; all flops on rising edge.
REQ-004 n_rst  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  plaintext block offered.
REQ-006 in_ready  output  1  engine accepts a block this cycle.
REQ-007 in_block  input  128  plaintext; byte 0 in [127:120], column-major.
REQ-008 key_ready  input  1  key schedule stable (key generator's change_key_done).
REQ-009 orig_key  input  128  cipher key for round 0.
REQ-010 cur_key  input  128  round key for cur_round, combinationally valid in the same cycle.
REQ-011 cur_round  output  4  round index presented to the key generator.
REQ-012 out_valid  output  1  ciphertext available.
REQ-013 out_ready  input  1  downstream accepts ciphertext.
REQ-014 out_block  output  128  ciphertext, same byte order as in_block.
REQ-015 busy  output  1  high in any state except IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ROUND, DONE.
REQ-017 in_ready SHALL be 1 only when state is IDLE and key_ready is 1.
REQ-018 On an in_valid&in_ready edge, state_reg SHALL load in_block^orig_key, rnd SHALL load 1, and the FSM SHALL go to ROUND.
REQ-019 In ROUND, cur_round SHALL equal rnd (1..10), and each cycle state_reg SHALL load AddRoundKey(MixColumns(ShiftRows(SubBytes(state_reg))), cur_key).
REQ-020 When rnd==NUM_ROUNDS, MixColumns SHALL be skipped, the result SHALL load out_block, out_valid SHALL be set, and the FSM SHALL go to DONE.
REQ-021 Otherwise rnd SHALL increment.
REQ-022 Latency SHALL be 11 cycles: acceptance at edge T gives out_valid=1 after edge T+11.
REQ-023 In IDLE and DONE, cur_round SHALL be 0.
REQ-024 In DONE, out_valid and out_block SHALL hold until out_valid&out_ready; that edge SHALL clear out_valid and return the FSM to IDLE.
REQ-025 No new block SHALL be accepted before that return, including the cycle of the handshake itself.
REQ-026 in_valid while in_ready is 0 SHALL be ignored.
REQ-027 If key_ready falls during ROUND, the current block SHALL continue; the result is undefined and the key generator owns that rule.
REQ-028 MixColumns SHALL use GF(2^8) with polynomial 0x11B, via xtime.

Reset
REQ-029 With n_rst=0 at a clock edge: FSM=IDLE, rnd=0, state_reg=0, out_block=0, out_valid=0, cur_round=0, busy=0.
REQ-030 Reset mid-operation SHALL abandon the block with no output.
REQ-031 in_ready SHALL be 0 during reset.

Configuration
REQ-032 Macro AES_ROUND_ENGINE_BLKCNT_EN, when defined, SHALL add output port blk_count [CNT_W-1:0].
REQ-033 blk_count SHALL increment on every out handshake, wrap from all-ones to 0, and reset to 0.
REQ-034 When the macro is undefined, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-035 Shared package aes_pkg SHALL hold the state enum, NUM_ROUNDS, and the xtime function.
REQ-036 SubBytes SHALL reuse the existing SBox module, 16 instances.
REQ-037 A single new sub-module mix_columns SHALL exist: combinational, 128-bit in/out.
REQ-038 ShiftRows SHALL be pure wiring in the top module.

Verification
REQ-039 Key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> out_block 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 11 cycles after acceptance.
REQ-040 Key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; cur_round sequence 1..10, then 0.
REQ-041 Hold out_ready=0 for 5 cycles after out_valid -> out_block stable, in_ready=0 throughout, in_valid pulses ignored.
REQ-042 key_ready=0 with in_valid=1 -> in_ready=0, no acceptance; raise key_ready -> acceptance on the next edge.
REQ-043 Assert n_rst=0 at round 5 -> next cycle all outputs at reset values, and no out_valid for that block.
REQ-044 With AES_ROUND_ENGINE_BLKCNT_EN and CNT_W=2, 5 back-to-back blocks -> blk_count 1,2,3,0,1.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: engine FSM states, round count and GF(2^8) doubling.
package aes_pkg;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_state_e;

  localparam int NUM_ROUNDS = 10;

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/SBox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module SBox (
  input  logic [7:0] x,
  output logic [7:0] s
);
  import aes_pkg::*;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  logic [7:0] inv;
  logic [7:0] sq;

  // x^254 by square-and-multiply; maps 0 to 0 as the S-box requires.
  always_comb begin
    inv = 8'h01;
    sq  = x;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
  end

  assign s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
           ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

// File: rtl/mix_columns.sv
// AES MixColumns over four column-major 32-bit columns; purely combinational.
module mix_columns (
  input  logic [127:0] x,
  output logic [127:0] y
);
  import aes_pkg::*;

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = x[127-32*c -: 8];
    assign a1 = x[119-32*c -: 8];
    assign a2 = x[111-32*c -: 8];
    assign a3 = x[103-32*c -: 8];
    assign y[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign y[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign y[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign y[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end
endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryptor, one round per cycle, round keys from an external generator.
// AES_ROUND_ENGINE_BLKCNT_EN adds the blk_count completed-block counter port.
module aes_round_engine #(
  parameter int NUM_ROUNDS = 10,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_block,
  input  logic               key_ready,
  input  logic [127:0]       orig_key,
  input  logic [127:0]       cur_key,
  output logic [3:0]         cur_round,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_block,
  output logic               busy
`ifdef AES_ROUND_ENGINE_BLKCNT_EN
  ,
  output logic [CNT_W-1:0]   blk_count
`endif
);
  import aes_pkg::*;

  if (NUM_ROUNDS != 10 || CNT_W < 1) begin : g_cfg_err
    $error("aes_round_engine: only NUM_ROUNDS=10 and CNT_W>=1 are supported");
  end

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  aes_state_e   state, state_nxt;
  logic [3:0]   rnd;
  logic [127:0] state_reg, sb, sr, mc, rnd_out;
  logic         out_pend;
  logic         last_rnd;

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    SBox u_sbox (.x(state_reg[127-8*i -: 8]), .s(sb[127-8*i -: 8]));
  end

  // Row r rotates left by r columns; byte index is r + 4*c.
  for (genvar r = 0; r < 4; r++) begin : g_sr_row
    for (genvar c = 0; c < 4; c++) begin : g_sr_col
      assign sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
    end
  end

  mix_columns u_mix (.x(sr), .y(mc));

  assign last_rnd = (rnd == LAST_RND);
  assign rnd_out  = (last_rnd ? sr : mc) ^ cur_key;

  always_comb begin
    state_nxt = state;
    in_ready  = n_rst && (state == IDLE) && key_ready;
    cur_round = (state == ROUND) ? rnd : 4'd0;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (in_valid && in_ready) state_nxt = ROUND;
      ROUND:   if (last_rnd) state_nxt = DONE;
      DONE:    if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ciphertext is registered into out_block on the last round and presented
  // one cycle later, giving 11 cycles from acceptance to out_valid.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= IDLE;
      rnd       <= '0;
      state_reg <= '0;
      out_block <= '0;
      out_valid <= 1'b0;
      out_pend  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid && in_ready) begin
          state_reg <= in_block ^ orig_key;
          rnd       <= 4'd1;
        end
        ROUND: begin
          state_reg <= rnd_out;
          if (last_rnd) begin
            out_block <= rnd_out;
            out_pend  <= 1'b1;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        DONE: begin
          if (out_pend) begin
            out_valid <= 1'b1;
            out_pend  <= 1'b0;
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AES_ROUND_ENGINE_BLKCNT_EN
  always_ff @(posedge clk) begin
    if (!n_rst)                      blk_count <= '0;
    else if (out_valid && out_ready) blk_count <= blk_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_aes_round_engine.sv
// Randomized self-checking bench for aes_round_engine against a byte-level AES model.
module tb_aes_round_engine;
  localparam int CNT_W = 2;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         key_ready = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_block = '0;
  logic [127:0] orig_key = '0;
  logic [127:0] cur_key;
  logic         in_ready, out_valid, busy;
  logic [3:0]   cur_round;
  logic [127:0] out_block;
`ifdef AES_ROUND_ENGINE_BLKCNT_EN
  logic [CNT_W-1:0] blk_count;
`endif

  int errs = 0;
  int checks = 0;
  int hs_cnt = 0;
  logic [7:0]   sbt [256];
  logic [127:0] rk [16];

  aes_round_engine #(.NUM_ROUNDS(10), .CNT_W(CNT_W)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .key_ready(key_ready), .orig_key(orig_key),
    .cur_key(cur_key), .cur_round(cur_round), .out_valid(out_valid),
    .out_ready(out_ready), .out_block(out_block), .busy(busy)
`ifdef AES_ROUND_ENGINE_BLKCNT_EN
    , .blk_count(blk_count)
`endif
  );

  always #5 clk = ~clk;

  // Key generator stand-in: round key for the presented round index.
  assign cur_key = rk[cur_round];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from first principles: brute-force inverse, then bitwise affine map.
  task automatic build_sbox();
    logic [7:0] inv, b, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbt[x] = b;
    end
  endtask

  task automatic expand_key(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = '0;
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] blk;
    blk = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbt[blk[127-8*i -: 8]];
      for (int rr = 0; rr < 4; rr++)
        for (int c = 0; c < 4; c++) t[rr+4*c] = s[rr+4*((c+rr)%4)];
      for (int c = 0; c < 4; c++) begin
        if (r < 10) begin
          s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end else begin
          for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
        end
      end
      for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = s[i];
      blk = blk ^ rk[r];
    end
    return blk;
  endfunction

  task automatic run_block(input logic [127:0] k, input logic [127:0] pt,
                           input int hold, input int kdrop, output logic [127:0] got);
    logic [127:0] exp;
    logic [3:0]   er;
    int           lat;
    bit           seq_ok;
    expand_key(k);
    exp = aes_ref(pt);
    orig_key = k;
    in_block = pt;
    in_valid = 1'b1;
    if (kdrop > 0) begin
      key_ready = 1'b0;
      repeat (kdrop) begin
        @(posedge clk); #1;
        chk("kr_low_in_ready", 128'(in_ready), 128'(0));
        chk("kr_low_no_accept", 128'(busy), 128'(0));
      end
      key_ready = 1'b1;
    end
    #1;
    chk("in_ready_idle", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    seq_ok = 1'b1;
    while (!out_valid && lat < 30) begin
      er = (lat < 10) ? 4'(lat + 1) : 4'd0;
      if (cur_round !== er) seq_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 128'(lat), 128'(11));
    chk("round_seq", 128'(seq_ok), 128'(1));
    chk("ciphertext", out_block, exp);
    got = out_block;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("hold_valid", 128'(out_valid), 128'(1));
      chk("hold_block", out_block, exp);
      chk("hold_in_ready", 128'(in_ready), 128'(0));
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    hs_cnt++;
    chk("hs_clears_valid", 128'(out_valid), 128'(0));
    chk("hs_no_accept", 128'(busy), 128'(0));
`ifdef AES_ROUND_ENGINE_BLKCNT_EN
    chk("blk_count", 128'(blk_count), 128'(hs_cnt % (1 << CNT_W)));
`endif
  endtask

  task automatic reset_mid();
    bit seen;
    expand_key(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
    orig_key = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    in_block = 128'hdeadbeef0123456789abcdeffedcba98;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("mid_round5", 128'(cur_round), 128'(5));
    n_rst = 1'b0;
    @(posedge clk); #1;
    chk("mrst_valid", 128'(out_valid), 128'(0));
    chk("mrst_busy", 128'(busy), 128'(0));
    chk("mrst_round", 128'(cur_round), 128'(0));
    chk("mrst_block", out_block, 128'(0));
    chk("mrst_in_ready", 128'(in_ready), 128'(0));
`ifdef AES_ROUND_ENGINE_BLKCNT_EN
    chk("mrst_blk_count", 128'(blk_count), 128'(0));
`endif
    n_rst = 1'b1;
    hs_cnt = 0;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("mrst_no_output", 128'(seen), 128'(0));
  endtask

  initial begin
    logic [127:0] got;
    for (int r = 0; r < 16; r++) rk[r] = '0;
    build_sbox();
    key_ready = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_cur_round", 128'(cur_round), 128'(0));
    chk("rst_out_block", out_block, 128'(0));
    in_valid = 1'b0;
    n_rst = 1'b1;
    @(posedge clk); #1;

    run_block(128'h000102030405060708090a0b0c0d0e0f,
              128'h00112233445566778899aabbccddeeff, 0, 0, got);
    chk("vec_appendix_c", got, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    run_block(128'h2b7e151628aed2a6abf7158809cf4f3c,
              128'h3243f6a8885a308d313198a2e0370734, 5, 2, got);
    chk("vec_appendix_b", got, 128'h3925841d02dc09fbdc118597196a0b32);

    reset_mid();

    for (int n = 0; n < 6; n++)
      run_block({$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom},
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), got);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
